// File: rtl/phase_seq_pkg.sv
// Shared types and constants for the three-phase FILL/RUN/DRAIN sequencer.
package phase_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_ARM   = 3'd2,
        ST_WAIT  = 3'd3,
        ST_DONE  = 3'd4,
        ST_FAULT = 3'd5
    } state_e;

    typedef enum logic [1:0] {
        PH_FILL  = 2'd0,
        PH_RUN   = 2'd1,
        PH_DRAIN = 2'd2
    } phase_e;

    localparam int T_FILL_DEF  = 300;
    localparam int T_RUN_DEF   = 420;
    localparam int T_DRAIN_DEF = 480;

    localparam logic [1:0] PH_LAST = 2'd2;

endpackage

// File: rtl/phase_duration_sel.sv
// Combinational phase -> timer duration lookup; the parent registers the result.
module phase_duration_sel
    import phase_seq_pkg::*;
#(
    parameter int W       = 10,
    parameter int T_FILL  = T_FILL_DEF,
    parameter int T_RUN   = T_RUN_DEF,
    parameter int T_DRAIN = T_DRAIN_DEF
) (
    input  logic [1:0]   phase,
    output logic [W-1:0] seconds
);

    always_comb begin
        seconds = '0;
        case (phase)
            PH_FILL:  seconds = W'(T_FILL);
            PH_RUN:   seconds = W'(T_RUN);
            PH_DRAIN: seconds = W'(T_DRAIN);
            default:  seconds = '0;
        endcase
    end

endmodule

// File: rtl/phase_sequencer.sv
// Drives a countdown timer through FILL, RUN and DRAIN; all outputs are registered or decoded from state.
// Optional door interlock (FAULT state, door_closed/fault ports) enabled by DOOR_INTERLOCK_EN.
module phase_sequencer
    import phase_seq_pkg::*;
#(
    parameter int W       = 10,
    parameter int T_FILL  = T_FILL_DEF,
    parameter int T_RUN   = T_RUN_DEF,
    parameter int T_DRAIN = T_DRAIN_DEF
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         go,
    input  logic         abort,
    input  logic         timer_done,
`ifdef DOOR_INTERLOCK_EN
    input  logic         door_closed,
    output logic         fault,
`endif
    output logic [W-1:0] timer_seconds,
    output logic         timer_start,
    output logic [1:0]   phase,
    output logic         busy,
    output logic         cycle_done,
    output logic         aborted
);

    localparam logic [2:0] S_IDLE  = ST_IDLE;
    localparam logic [2:0] S_LOAD  = ST_LOAD;
    localparam logic [2:0] S_ARM   = ST_ARM;
    localparam logic [2:0] S_WAIT  = ST_WAIT;
    localparam logic [2:0] S_DONE  = ST_DONE;
    localparam logic [2:0] S_FAULT = ST_FAULT;

    localparam longint MAX_DUR = (longint'(1) << W) - 1;

    if (T_FILL < 0 || T_RUN < 0 || T_DRAIN < 0 ||
        T_FILL > MAX_DUR || T_RUN > MAX_DUR || T_DRAIN > MAX_DUR) begin : g_dur_range
        $error("phase_sequencer: a phase duration does not fit in W bits");
    end

    logic [2:0]   state;
    logic [2:0]   state_nxt;
    logic [1:0]   phase_q;
    logic [1:0]   phase_nxt;
    logic         aborted_q;
    logic         aborted_nxt;
    logic [W-1:0] dur_nxt;
    logic         door_ok;

`ifdef DOOR_INTERLOCK_EN
    assign door_ok = door_closed;
`else
    assign door_ok = 1'b1;
`endif

    // Duration is looked up for the phase being entered so it is already registered during LOAD.
    phase_duration_sel #(
        .W       (W),
        .T_FILL  (T_FILL),
        .T_RUN   (T_RUN),
        .T_DRAIN (T_DRAIN)
    ) u_dur_sel (
        .phase   (phase_nxt),
        .seconds (dur_nxt)
    );

    always_comb begin
        state_nxt   = state;
        phase_nxt   = phase_q;
        aborted_nxt = 1'b0;
        if (state != S_IDLE && abort) begin
            state_nxt   = S_IDLE;
            phase_nxt   = PH_FILL;
            aborted_nxt = 1'b1;
        end else begin
            case (state)
                S_IDLE: begin
                    if (go && !abort && door_ok) begin
                        state_nxt = S_LOAD;
                        phase_nxt = PH_FILL;
                    end
                end
                S_LOAD: state_nxt = S_ARM;
                // timer_done still reflects the pre-load count here, so it is not looked at.
                S_ARM:  state_nxt = S_WAIT;
                S_WAIT: begin
                    if (timer_done) begin
                        if (phase_q == PH_LAST) begin
                            state_nxt = S_DONE;
                        end else begin
                            state_nxt = S_LOAD;
                            phase_nxt = phase_q + 2'd1;
                        end
                    end
                end
                S_DONE:  state_nxt = S_IDLE;
                S_FAULT: state_nxt = S_FAULT;
                default: state_nxt = S_IDLE;
            endcase
            if (!door_ok && (state == S_LOAD || state == S_ARM || state == S_WAIT)) begin
                state_nxt = S_FAULT;
                phase_nxt = phase_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= S_IDLE;
            phase_q       <= 2'd0;
            aborted_q     <= 1'b0;
            timer_seconds <= '0;
        end else begin
            state     <= state_nxt;
            phase_q   <= phase_nxt;
            aborted_q <= aborted_nxt;
            if (state_nxt == S_LOAD) begin
                timer_seconds <= dur_nxt;
            end
        end
    end

    assign timer_start = (state == S_LOAD);
    assign busy        = (state != S_IDLE);
    assign cycle_done  = (state == S_DONE);
    assign aborted     = aborted_q;
    assign phase       = phase_q;
`ifdef DOOR_INTERLOCK_EN
    assign fault       = (state == S_FAULT);
`endif

endmodule

// File: doc/phase_sequencer.md
Name: phase_sequencer

Overview:
Three-phase process controller (FILL 300 s, RUN 420 s, DRAIN 480 s) sitting directly upstream of the 10-bit countdown timer. It loads each phase duration into the timer, pulses the timer's start, waits for the timer's done level, then advances to the next phase. It reports the current phase, busy, and cycle completion/abort to the front-panel logic.

Parameters:
W, 10, timer duration width (max 1023 s)
T_FILL, 300, phase 0 duration in timer ticks
T_RUN, 420, phase 1 duration in timer ticks
T_DRAIN, 480, phase 2 duration in timer ticks

Ports:
clk  in  1  system clock, same clock as the countdown timer
reset  in  1  synchronous, active-high
go  in  1  level; sampled in IDLE only; starts a full cycle
abort  in  1  level; cancels any in-progress cycle
timer_done  in  1  timer output; 1 when its count is 0
timer_seconds  out  W  duration presented to the timer; valid whenever timer_start=1
timer_start  out  1  one-cycle load/start pulse to the timer
phase  out  2  0=FILL, 1=RUN, 2=DRAIN; 3 never driven
busy  out  1  1 in any state other than IDLE
cycle_done  out  1  one-cycle pulse after DRAIN expires
aborted  out  1  one-cycle pulse when abort cancels a cycle

Behaviour:
- Reset: state=IDLE, phase=0, timer_seconds=0, timer_start=0, busy=0, cycle_done=0, aborted=0. Fault flag cleared (see Optional Feature).
- All outputs registered or Moore-decoded from registered state. No combinational path from any input to any output.
- States: IDLE, LOAD, ARM, WAIT, DONE.
- IDLE: go=1 and abort=0 -> LOAD, phase<=0.
- LOAD: timer_start=1 for exactly one cycle; timer_seconds=duration(phase) -> ARM.
- ARM: one-cycle blanking. timer_done is ignored because the timer's done flag is stale until one cycle after its load -> WAIT.
- WAIT: on timer_done=1:
  - phase<2: phase<=phase+1 -> LOAD.
  - phase=2: -> DONE.
- DONE: cycle_done=1 for one cycle; phase held at 2 -> IDLE.
- timer_seconds holds its last loaded value outside LOAD.
- Latency: go sampled at edge k gives timer_start high during cycle k+1. Phase expiry seen at edge j gives the next timer_start during cycle j+1.
- Zero-duration phase: timer_done is already 1 in WAIT, so the sequencer advances after one WAIT cycle. Each phase therefore costs at least 3 cycles (LOAD, ARM, WAIT).
- abort: priority reset > abort > go.
  - abort=1 in any non-IDLE state -> IDLE at the next edge; aborted=1 for that one cycle; phase<=0.
  - No timer_start is issued on abort; the timer is left as-is.
  - abort in IDLE: no effect, aborted stays 0.
- go while busy: ignored. go held high through DONE starts a new cycle directly from IDLE (back-to-back).
- Reset mid-cycle: returns to IDLE within one edge; no cycle_done or aborted pulse.
- Duration width: parameters above 2^W-1 are a compile-time error (static assertion).

Optional Feature:
Macro DOOR_INTERLOCK_EN.
- Defined:
  - Adds input door_closed (1 bit) and output fault (1 bit, reset 0).
  - door_closed=0 while in LOAD/ARM/WAIT -> new state FAULT: fault=1, busy=1, phase held, no timer_start.
  - FAULT exits only on abort (-> IDLE with aborted pulse) or reset.
  - go in IDLE is ignored while door_closed=0.
- Undefined: no door_closed/fault ports; FAULT state absent.

Decomposition:
- Package phase_seq_pkg:
  - state enum (IDLE, LOAD, ARM, WAIT, DONE, FAULT)
  - phase enum (PH_FILL, PH_RUN, PH_DRAIN)
  - default duration constants 300/420/480
  - PH_LAST=2
- One sub-module, phase_duration_sel: combinational phase -> W-bit duration mux driven by the parameters, registered into timer_seconds by the parent.

Test Plan:
- Use T_FILL=3, T_RUN=5, T_DRAIN=2 with a behavioural countdown timer model. Pulse go -> timer_start pulses carry 3, 5, 2 in order; phase 0->1->2; exactly one cycle_done; busy deasserts the cycle after cycle_done.
- Verify the ARM blanking: pre-set timer_done=1 before go -> sequencer does not advance in ARM; FILL still waits the full 3 ticks.
- Set T_RUN=0 -> RUN lasts exactly 3 cycles (LOAD, ARM, WAIT); DRAIN loads 2 next.
- Assert abort during RUN WAIT -> next edge IDLE, aborted=1 for one cycle, phase=0, no further timer_start, no cycle_done.
- Hold go high continuously -> second cycle's first timer_start (value 3) occurs 2 cycles after cycle_done; assert go while busy -> no effect.
- DOOR_INTERLOCK_EN defined: drop door_closed in FILL WAIT -> fault=1 next cycle, phase=0 held; abort -> IDLE, fault=0, aborted=1.
